sp_bank_unit: RTL and testbench

Banked, bounds-checked stack pointer unit: the parametrised successor of the single 16-bit stack pointer register.
- Holds BANKS independent stack pointers (e.g. bank 0 user, bank 1 kernel), one of them active.
- Supports inc/dec by STEP, signed frame adjust, and direct bus load.
- Checks every arithmetic update against per-bank lower/upper limits; raises sticky fault flags instead of wrapping.
- Sits in the CPU datapath between the bus and the address mux.

---
 rtl/sp_pkg.sv | 33 +++
 rtl/sp_bank_unit_if.sv | 33 +++
 rtl/sp_bound_check.sv | 36 +++
 rtl/sp_bank_unit.sv | 121 ++++++++++++
 tb/tb_sp_bank_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/sp_pkg.sv
// Shared definitions for the banked stack pointer unit and its control decoder.
// Holds the limit-select constants, the op-select enum and the request-priority decoder.
package sp_pkg;

    localparam logic LIM_LO = 1'b0;
    localparam logic LIM_HI = 1'b1;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_LOAD,
        OP_ADJ,
        OP_INC,
        OP_DEC
    } sp_op_e;

    // Only one SP update per cycle. A load beats an adjust, and an adjust beats
    // inc/dec. When inc and dec are both high they cancel out.
    function automatic sp_op_e decode_op(input logic bus_we, input logic adj_en,
                                         input logic inc, input logic dec);
        sp_op_e op;
        op = OP_NONE;
        if (bus_we)
            op = OP_LOAD;
        else if (adj_en)
            op = OP_ADJ;
        else if (inc && !dec)
            op = OP_INC;
        else if (dec && !inc)
            op = OP_DEC;
        return op;
    endfunction

endpackage

// File: rtl/sp_bank_unit_if.sv
// Control and result bundle between the CPU datapath and the banked stack pointer unit.
interface sp_bank_unit_if #(
    parameter int WIDTH = 16,
    parameter int BW    = 1
);
    logic [WIDTH-1:0] val;
    logic [BW-1:0]    bank;
    logic             bank_we;
    logic [BW-1:0]    bank_in;
    logic [WIDTH-1:0] bus_in;
    logic             bus_we;
    logic             inc;
    logic             dec;
    logic             adj_en;
    logic [WIDTH-1:0] adj;
    logic             lim_we;
    logic             lim_sel;
    logic             hi_fault;
    logic             lo_fault;
    logic             fault_clr;

    modport master (
        input  val, bank, hi_fault, lo_fault,
        output bank_we, bank_in, bus_in, bus_we, inc, dec, adj_en, adj,
               lim_we, lim_sel, fault_clr
    );

    modport slave (
        output val, bank, hi_fault, lo_fault,
        input  bank_we, bank_in, bus_in, bus_we, inc, dec, adj_en, adj,
               lim_we, lim_sel, fault_clr
    );
endinterface

// File: rtl/sp_bound_check.sv
// Combinational candidate generation and limit check for one stack pointer update.
// The delta is a WIDTH-bit two's-complement value. dir_down supplies the sign bit for the extended add.
module sp_bound_check #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] sp,
    input  logic [WIDTH-1:0] delta,
    input  logic             dir_down,
    input  logic [WIDTH-1:0] lim_lo,
    input  logic [WIDTH-1:0] lim_hi,
    output logic [WIDTH-1:0] cand,
    output logic             hi_violation,
    output logic             lo_violation
);
    logic [WIDTH:0] sum;
    logic           out_of_range;
    logic           inverted;
    logic           raw_hi;
    logic           raw_lo;

    // Bit WIDTH of the sum is set on a carry when moving up, or on a borrow when moving down.
    assign sum          = {1'b0, sp} + {dir_down, delta};
    assign cand         = sum[WIDTH-1:0];
    assign out_of_range = sum[WIDTH];
    assign inverted     = lim_lo > lim_hi;

    // Once the sum has wrapped, the truncated candidate is meaningless.
    // The unsigned limit compares only count while the sum is still in range.
    assign raw_hi = (out_of_range && !dir_down) || (!out_of_range && (cand > lim_hi));
    assign raw_lo = (out_of_range && dir_down)  || (!out_of_range && (cand < lim_lo));

    // With inverted limits no candidate can pass. That case is reported as an upper violation only.
    assign hi_violation = inverted || raw_hi;
    assign lo_violation = !hi_violation && raw_lo;

endmodule

// File: rtl/sp_bank_unit.sv
// Banked, bounds-checked stack pointer unit. Each bank has its own SP and lower/upper limits.
// Checked arithmetic that would leave the limits is blocked and raises a sticky fault flag.
module sp_bank_unit
    import sp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BANKS     = 2,
    parameter int STEP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    sp_bank_unit_if.slave sp
);
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [WIDTH-1:0] sp_all [BANKS];
    logic [WIDTH-1:0] lo_all [BANKS];
    logic [WIDTH-1:0] hi_all [BANKS];

    logic [BW-1:0] bank_reg, bank_next;
    logic          hi_fault_reg, hi_fault_next;
    logic          lo_fault_reg, lo_fault_next;

    sp_op_e           op;
    logic [WIDTH-1:0] delta;
    logic             dir_down;
    logic             checked;
    logic [WIDTH-1:0] cand;
    logic             hi_v, lo_v;
    logic             commit;

    always_comb begin
        op       = decode_op(sp.bus_we, sp.adj_en, sp.inc, sp.dec);
        delta    = '0;
        dir_down = 1'b0;
        case (op)
            OP_INC: delta = WIDTH'(STEP);
            OP_DEC: begin
                delta    = WIDTH'(0) - WIDTH'(STEP);
                dir_down = 1'b1;
            end
            OP_ADJ: begin
                delta    = sp.adj;
                dir_down = sp.adj[WIDTH-1];
            end
            default: ;
        endcase
        checked = (op == OP_ADJ) || (op == OP_INC) || (op == OP_DEC);
        commit  = checked && !hi_v && !lo_v;
    end

    sp_bound_check #(.WIDTH(WIDTH)) u_bound_check (
        .sp           (sp_all[bank_reg]),
        .delta        (delta),
        .dir_down     (dir_down),
        .lim_lo       (lo_all[bank_reg]),
        .lim_hi       (hi_all[bank_reg]),
        .cand         (cand),
        .hi_violation (hi_v),
        .lo_violation (lo_v)
    );

    // Only the bank selected before this edge is written. A bank switch in the same cycle takes effect afterwards.
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
        logic [WIDTH-1:0] sp_reg, lo_reg, hi_reg;
        logic             sel;

        assign sel = (bank_reg == BW'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                sp_reg <= WIDTH'(RESET_VAL);
                lo_reg <= '0;
                hi_reg <= '1;
            end else if (sel) begin
                if (op == OP_LOAD)
                    sp_reg <= sp.bus_in;
                else if (commit)
                    sp_reg <= cand;
                if (sp.lim_we) begin
                    if (sp.lim_sel == LIM_HI)
                        hi_reg <= sp.bus_in;
                    else
                        lo_reg <= sp.bus_in;
                end
            end
        end

        assign sp_all[gi] = sp_reg;
        assign lo_all[gi] = lo_reg;
        assign hi_all[gi] = hi_reg;
    end

    always_comb begin
        bank_next = bank_reg;
        if (sp.bank_we && (32'(sp.bank_in) < BANKS))
            bank_next = sp.bank_in;
        // A new violation beats a clear in the same cycle.
        hi_fault_next = (hi_fault_reg && !sp.fault_clr) || (checked && hi_v);
        lo_fault_next = (lo_fault_reg && !sp.fault_clr) || (checked && lo_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_reg     <= '0;
            hi_fault_reg <= 1'b0;
            lo_fault_reg <= 1'b0;
        end else begin
            bank_reg     <= bank_next;
            hi_fault_reg <= hi_fault_next;
            lo_fault_reg <= lo_fault_next;
        end
    end

    assign sp.val      = sp_all[bank_reg];
    assign sp.bank     = bank_reg;
    assign sp.hi_fault = hi_fault_reg;
    assign sp.lo_fault = lo_fault_reg;

endmodule

// File: tb/tb_sp_bank_unit.sv
// Directed bench for sp_bank_unit (WIDTH=16, BANKS=2, STEP=1, RESET_VAL=0).
// Expected values are worked out by hand for each directed step.
module tb_sp_bank_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sp_bank_unit_if #(.WIDTH(16), .BW(1)) sp_if ();

    sp_bank_unit #(
        .WIDTH     (16),
        .BANKS     (2),
        .STEP      (1),
        .RESET_VAL (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sp  (sp_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic idle();
        sp_if.bank_we   = 1'b0;
        sp_if.bank_in   = '0;
        sp_if.bus_in    = '0;
        sp_if.bus_we    = 1'b0;
        sp_if.inc       = 1'b0;
        sp_if.dec       = 1'b0;
        sp_if.adj_en    = 1'b0;
        sp_if.adj       = '0;
        sp_if.lim_we    = 1'b0;
        sp_if.lim_sel   = 1'b0;
        sp_if.fault_clr = 1'b0;
    endtask

    // Apply the currently driven inputs at one posedge, sample shortly after it, then return the inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_lim(input logic sel, input logic [15:0] v);
        sp_if.lim_we  = 1'b1;
        sp_if.lim_sel = sel;
        sp_if.bus_in  = v;
        step();
    endtask

    task automatic load_sp(input logic [15:0] v);
        sp_if.bus_we = 1'b1;
        sp_if.bus_in = v;
        step();
    endtask

    task automatic clr_faults();
        sp_if.fault_clr = 1'b1;
        step();
    endtask

    task automatic expect_state(input string tag, input logic [15:0] v,
                                input logic hi, input logic lo);
        check({tag, ".val"}, 32'(sp_if.val), 32'(v));
        check({tag, ".hi"},  32'(sp_if.hi_fault), 32'(hi));
        check({tag, ".lo"},  32'(sp_if.lo_fault), 32'(lo));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst.bank", 32'(sp_if.bank), 32'd0);
        expect_state("rst", 16'h0000, 1'b0, 1'b0);

        // Three increments from the reset value.
        for (int i = 1; i <= 3; i++) begin
            sp_if.inc = 1'b1;
            step();
            expect_state($sformatf("inc%0d", i), 16'(i), 1'b0, 1'b0);
        end

        // Upper limit 4: landing exactly on the limit is legal, going past it is blocked.
        set_lim(1'b1, 16'h0004);
        sp_if.inc = 1'b1; step();
        expect_state("hi_edge", 16'h0004, 1'b0, 1'b0);
        sp_if.inc = 1'b1; step();
        expect_state("hi_block", 16'h0004, 1'b1, 1'b0);
        clr_faults();
        expect_state("hi_clr", 16'h0004, 1'b0, 1'b0);

        // Lower limit 1: a negative adjust below the limit is blocked, one landing on it is legal.
        load_sp(16'h0002);
        set_lim(1'b0, 16'h0001);
        sp_if.adj_en = 1'b1; sp_if.adj = 16'hFFFE; step();
        expect_state("adj_m2", 16'h0002, 1'b0, 1'b1);
        clr_faults();
        sp_if.adj_en = 1'b1; sp_if.adj = 16'hFFFF; step();
        expect_state("adj_m1", 16'h0001, 1'b0, 1'b0);
        sp_if.dec = 1'b1; step();
        expect_state("dec_lo", 16'h0001, 1'b0, 1'b1);
        clr_faults();

        // Carry out of 16 bits is an upper violation. A bus load is unchecked and wins over inc.
        set_lim(1'b1, 16'hFFFF);
        load_sp(16'hFFFF);
        sp_if.inc = 1'b1; step();
        expect_state("carry", 16'hFFFF, 1'b1, 1'b0);
        clr_faults();
        sp_if.bus_we = 1'b1; sp_if.bus_in = 16'h1234; sp_if.inc = 1'b1; step();
        expect_state("load_pri", 16'h1234, 1'b0, 1'b0);

        // A bank switch takes effect after this edge. The same-cycle inc still goes to bank 0.
        load_sp(16'h0010);
        sp_if.bank_we = 1'b1; sp_if.bank_in = 1'b1; sp_if.inc = 1'b1; step();
        check("sw1.bank", 32'(sp_if.bank), 32'd1);
        check("sw1.val",  32'(sp_if.val),  32'h0000);
        sp_if.bank_we = 1'b1; sp_if.bank_in = 1'b0; step();
        check("sw0.bank", 32'(sp_if.bank), 32'd0);
        check("sw0.val",  32'(sp_if.val),  32'h0011);

        // A limit write in the same cycle as an inc: the bounds check still uses the old limit.
        load_sp(16'h0005);
        sp_if.lim_we = 1'b1; sp_if.lim_sel = 1'b1; sp_if.bus_in = 16'h0005; sp_if.inc = 1'b1; step();
        expect_state("old_lim", 16'h0006, 1'b0, 1'b0);
        sp_if.inc = 1'b1; step();
        expect_state("new_lim", 16'h0006, 1'b1, 1'b0);
        clr_faults();

        // Inverted limits (lo=0x100 > hi=5): every checked update is blocked and only hi_fault sets.
        set_lim(1'b0, 16'h0100);
        sp_if.dec = 1'b1; step();
        expect_state("inverted", 16'h0006, 1'b1, 1'b0);
        clr_faults();
        set_lim(1'b1, 16'hFFFF);
        set_lim(1'b0, 16'h0000);

        // inc and dec together cancel. adj_en beats inc.
        sp_if.inc = 1'b1; sp_if.dec = 1'b1; step();
        expect_state("inc_dec", 16'h0006, 1'b0, 1'b0);
        sp_if.adj_en = 1'b1; sp_if.adj = 16'h0002; sp_if.inc = 1'b1; step();
        expect_state("adj_pri", 16'h0008, 1'b0, 1'b0);

        // A clear in the same cycle as a new violation: the set wins.
        set_lim(1'b1, 16'h0008);
        sp_if.inc = 1'b1; sp_if.fault_clr = 1'b1; step();
        expect_state("clr_vs_set", 16'h0008, 1'b1, 1'b0);

        // Reset part-way through a sequence, with bank 1 active and holding a nonzero SP.
        sp_if.bank_we = 1'b1; sp_if.bank_in = 1'b1; step();
        sp_if.inc = 1'b1; step();
        check("b1_inc.val", 32'(sp_if.val), 32'h0001);
        rst = 1'b1;
        sp_if.inc = 1'b1;
        step();
        rst = 1'b0;
        check("rst2.bank", 32'(sp_if.bank), 32'd0);
        expect_state("rst2", 16'h0000, 1'b0, 1'b0);
        sp_if.bank_we = 1'b1; sp_if.bank_in = 1'b1; step();
        check("rst2.b1", 32'(sp_if.val), 32'h0000);
        sp_if.bank_we = 1'b1; sp_if.bank_in = 1'b0; step();
        sp_if.inc = 1'b1; step();
        expect_state("rst2_inc", 16'h0001, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
